// File: rtl/pipelined_rca.sv
// pipelined_rca: WIDTH-bit a+b+cin, carry chain cut into CHUNK-bit registered ripple segments.
// Define PIPE_RCA_OVF_EN to add the signed-overflow output ovf.
module pipelined_rca #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef PIPE_RCA_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int STAGES = WIDTH / CHUNK;

  logic w_adv;

  if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_cfg
    $error("pipelined_rca: WIDTH must be a multiple of CHUNK");
  end

  // Stage k keeps only the operand bits still to be added and the sum bits already made.
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * CHUNK;
    localparam int AW = WIDTH - LO;
    localparam int SW = LO + CHUNK;

    logic [AW-1:0]    w_a;
    logic [AW-1:0]    w_b;
    logic             w_ci;
    logic             w_vi;
    logic [CHUNK:0]   w_c;
    logic [CHUNK-1:0] w_s;
    logic [SW-1:0]    w_s_nxt;
    logic [SW-1:0]    r_s;
    logic             r_c;
    logic             r_v;

    if (k == 0) begin : g_head
      assign w_a     = a;
      assign w_b     = b;
      assign w_ci    = cin;
      assign w_vi    = in_valid;
      assign w_s_nxt = w_s;
    end else begin : g_skew
      logic [AW-1:0] r_a;
      logic [AW-1:0] r_b;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= g_stg[k-1].w_a[AW+CHUNK-1:CHUNK];
          r_b <= g_stg[k-1].w_b[AW+CHUNK-1:CHUNK];
        end
      end

      assign w_a     = r_a;
      assign w_b     = r_b;
      assign w_ci    = g_stg[k-1].r_c;
      assign w_vi    = g_stg[k-1].r_v;
      assign w_s_nxt = {w_s, g_stg[k-1].r_s};
    end

    always_comb begin
      w_c    = '0;
      w_s    = '0;
      w_c[0] = w_ci;
      for (int i = 0; i < CHUNK; i++) begin
        w_s[i]   = w_a[i] ^ w_b[i] ^ w_c[i];
        w_c[i+1] = (w_a[i] & w_b[i]) |
                   (w_c[i] & (w_a[i] ^ w_b[i]));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s <= '0;
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (w_adv) begin
        r_s <= w_s_nxt;
        r_c <= w_c[CHUNK];
        r_v <= w_vi;
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].r_v;
  assign sum       = g_stg[STAGES-1].r_s;
  assign cout      = g_stg[STAGES-1].r_c;
  assign w_adv     = !out_valid || out_ready;
  assign in_ready  = w_adv;

`ifdef PIPE_RCA_OVF_EN
  logic r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      r_ovf <= g_stg[STAGES-1].w_c[CHUNK-1] ^ g_stg[STAGES-1].w_c[CHUNK];
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_pipelined_rca.sv
// tb_pipelined_rca: directed bench with a result scoreboard for pipelined_rca.
// Covers the 16/4 pipe and a 4/4 single-stage instance.
module tb_pipelined_rca;

  localparam int STAGES = 4;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
    int          t;
    bit          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  logic        v4;
  logic        r4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        ci4;
  logic        ov4;
  logic [3:0]  s4;
  logic        co4;
  logic        of4;

  exp_t q[$];
  int   n_pass;
  int   n_tot;
  int   cyc;
  bit   lat_on;

  pipelined_rca #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum),
`ifdef PIPE_RCA_OVF_EN
    .cout(cout), .ovf(ovf)
`else
    .cout(cout)
`endif
  );

  pipelined_rca #(.WIDTH(4), .CHUNK(4)) u4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v4), .in_ready(r4),
    .a(a4), .b(b4), .cin(ci4),
    .out_valid(ov4), .out_ready(1'b1),
    .sum(s4),
`ifdef PIPE_RCA_OVF_EN
    .cout(co4), .ovf(of4)
`else
    .cout(co4)
`endif
  );

`ifndef PIPE_RCA_OVF_EN
  assign ovf = 1'b0;
  assign of4 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_tot++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
    exp_t e;
    logic [16:0] r;
    r     = {1'b0, x} + {1'b0, y} + {16'd0, c};
    e.s   = r[15:0];
    e.c   = r[16];
    e.o   = (x[15] == y[15]) && (r[15] != x[15]);
    e.t   = cyc;
    e.lat = lat_on;
    return e;
  endfunction

  // One clock: sample both handshakes, score the output, advance to next negedge.
  task automatic tick(output bit acc);
    bit   drn;
    exp_t e;
    #1;
    acc = in_valid && in_ready;
    drn = out_valid && out_ready;
    if (drn) begin
      if (q.size() == 0) begin
        chk("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("sum", 32'(sum), 32'(e.s));
        chk("cout", 32'(cout), 32'(e.c));
`ifdef PIPE_RCA_OVF_EN
        chk("ovf", 32'(ovf), 32'(e.o));
`endif
        if (e.lat) chk("latency", 32'(cyc - e.t), 32'(STAGES));
      end
    end
    if (acc) q.push_back(model(a, b, cin));
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    bit acc;
    in_valid = 1'b0;
    for (int i = 0; i < 60 && q.size() > 0; i++) tick(acc);
    chk("drain_left", 32'(q.size()), 32'd0);
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c);
    bit acc;
    in_valid = 1'b1;
    a   = x;
    b   = y;
    cin = c;
    tick(acc);
    if (!acc) chk("send_accept", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  initial begin
    bit          acc;
    int          bi;
    bit          stall;
    logic [15:0] hs;
    logic        hc;
    logic [15:0] bpa[12];
    logic [15:0] bpb[12];
    logic        bpc[12];

    n_pass = 0; n_tot = 0; cyc = 0; lat_on = 1'b1;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; ci4 = 1'b0;
    hs = '0; hc = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // full carry ripple through all stages
    send(16'hFFFF, 16'h0001, 1'b0);
    drain();
    send(16'hFFFF, 16'hFFFF, 1'b1);
    drain();

    // single-stage instance
    v4 = 1'b1; a4 = 4'd13; b4 = 4'd9; ci4 = 1'b1;
    #1 chk("u4_in_ready", 32'(r4), 32'd1);
    tick(acc);
    chk("u4_valid1", 32'(ov4), 32'd1);
    chk("u4_sum1", 32'(s4), 32'd7);
    chk("u4_cout1", 32'(co4), 32'd1);
    a4 = 4'd15; b4 = 4'd15; ci4 = 1'b1;
    tick(acc);
    chk("u4_sum2", 32'(s4), 32'd15);
    chk("u4_cout2", 32'(co4), 32'd1);
    v4 = 1'b0;
    tick(acc);
    chk("u4_bubble", 32'(ov4), 32'd0);

    // back-to-back stream
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a   = 16'(i);
      b   = 16'(16'h1000 * i);
      cin = 1'(i);
      tick(acc);
      if (!acc) chk("b2b_accept", 32'(acc), 32'd1);
    end
    drain();

    // backpressure: 5-cycle stall with results pending
    lat_on = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bpa[i] = 16'($urandom);
      bpb[i] = 16'($urandom);
      bpc[i] = 1'($urandom);
    end
    bi = 0;
    for (int c = 0; c < 20; c++) begin
      stall     = (c >= 8) && (c < 13);
      out_ready = !stall;
      in_valid  = (bi < 12);
      if (bi < 12) begin
        a = bpa[bi]; b = bpb[bi]; cin = bpc[bi];
      end
      #1;
      if (c == 8) begin
        hs = sum;
        hc = cout;
      end
      if (stall) begin
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_sum_hold", 32'(sum), 32'(hs));
        chk("bp_cout_hold", 32'(cout), 32'(hc));
      end
      tick(acc);
      if (acc) bi++;
    end
    out_ready = 1'b1;
    drain();
    chk("bp_beats_in", 32'(bi), 32'd12);
    lat_on = 1'b1;

    // reset with beats in flight
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'(16'h0100 + i); b = 16'h0011; cin = 1'b0;
      tick(acc);
    end
    in_valid = 1'b0;
    tick(acc);
    q.delete();
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < STAGES + 2; i++) begin
      #1 chk("no_stale", 32'(out_valid), 32'd0);
      tick(acc);
    end
    send(16'h1234, 16'h4321, 1'b0);
    drain();
    chk("post_rst_model", 32'(sum), 32'h5555);

`ifdef PIPE_RCA_OVF_EN
    send(16'h7FFF, 16'h0001, 1'b0);
    drain();
    send(16'h8000, 16'h8000, 1'b0);
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
